// File: rtl/vend_ctrl_pkg.sv
// Shared definitions for the vending controller slice.
//   state_t         : controller states
//   key_ev_t        : decoded winning key event
//   KEY_*           : bit positions inside flag_key
//   bin2bcd_const() : elaboration-time binary to 3-digit BCD
package vend_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DISPENSE,
        ST_CHANGE
    } state_t;

    typedef enum logic [1:0] {
        EV_NONE,
        EV_COIN,
        EV_BUY,
        EV_CANCEL
    } key_ev_t;

    localparam int unsigned KEY_COIN_A = 0;
    localparam int unsigned KEY_COIN_B = 1;
    localparam int unsigned KEY_BUY    = 2;
    localparam int unsigned KEY_CANCEL = 3;

    function automatic logic [11:0] bin2bcd_const(input int unsigned v);
        return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/vend_ctrl_bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-add-3, 8 steps).
//   sclk    : system clock
//   rst_n   : synchronous reset, active low
//   i_start : load i_bin and (re)start a conversion
//   i_bin   : binary value to convert
//   o_bcd   : BCD result, valid while o_done is high
//   o_done  : one-cycle pulse when the result is ready
module bin2bcd_seq (
    input  logic        sclk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [7:0]  i_bin,
    output logic [11:0] o_bcd,
    output logic        o_done
);

    logic [19:0] r_sh;
    logic [3:0]  r_cnt;
    logic        r_busy;
    logic [19:0] w_next;

    function automatic logic [19:0] dabble(input logic [19:0] s);
        logic [19:0] t;
        t = s;
        for (int unsigned d = 0; d < 3; d++) begin
            if (t[8 + 4*d +: 4] >= 4'd5)
                t[8 + 4*d +: 4] = t[8 + 4*d +: 4] + 4'd3;
        end
        return {t[18:0], 1'b0};
    endfunction

    assign w_next = dabble(r_sh);
    assign o_bcd  = r_sh[19:8];

    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            r_sh   <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            o_done <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (i_start) begin
                r_sh   <= {12'd0, i_bin};
                r_cnt  <= 4'd8;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_sh  <= w_next;
                r_cnt <= r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    r_busy <= 1'b0;
                    o_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vend_ctrl.sv
// Coin accounting / sale controller.
//   sclk, rst_n : clock, synchronous active-low reset
//   flag_key    : one-cycle key pulses [0] coin A [1] coin B [2] buy [3] cancel
//   rNum        : BCD display {price, credit-or-change}
//   dispensing  : high during DISPENSE
//   dispense_p  : pulse on DISPENSE entry
//   change_vld  : change/refund strobe, change_amt valid with it
//   coin_rej    : coin refused
//   short_p     : buy pressed with insufficient credit
module vend_ctrl
    import vend_ctrl_pkg::*;
#(
    parameter int unsigned PRICE      = 25,
    parameter int unsigned COIN_A     = 5,
    parameter int unsigned COIN_B     = 10,
    parameter int unsigned MAX_CREDIT = 95,
    parameter int unsigned HOLD_CYC   = 50_000_000
) (
    input  logic        sclk,
    input  logic        rst_n,
    input  logic [3:0]  flag_key,
    output logic [23:0] rNum,
    output logic        dispensing,
    output logic        dispense_p,
    output logic        change_vld,
    output logic [7:0]  change_amt,
    output logic        coin_rej,
    output logic        short_p
);

    localparam logic [11:0]  PRICE_BCD = bin2bcd_const(PRICE);
    localparam logic [7:0]   PRICE_V   = 8'(PRICE);
    localparam logic [7:0]   COIN_A_V  = 8'(COIN_A);
    localparam logic [7:0]   COIN_B_V  = 8'(COIN_B);
    localparam logic [8:0]   MAX_V     = 9'(MAX_CREDIT);
    localparam int unsigned  HCW       = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYC - 1);

    state_t         r_state;
    logic [7:0]     r_credit;
    logic [HCW-1:0] r_hold;
    logic [7:0]     r_last_src;
    logic [11:0]    r_bcd_low;

    key_ev_t        w_ev;
    logic [7:0]     w_coin;
    logic [8:0]     w_sum;
    logic [7:0]     w_src;
    logic           w_start;
    logic [11:0]    w_bcd;
    logic           w_done;

    // Only the highest-priority key is serviced: cancel > buy > coin B > coin A.
    always_comb begin
        w_ev   = EV_NONE;
        w_coin = '0;
        if (flag_key[KEY_CANCEL]) begin
            w_ev = EV_CANCEL;
        end else if (flag_key[KEY_BUY]) begin
            w_ev = EV_BUY;
        end else if (flag_key[KEY_COIN_B]) begin
            w_ev   = EV_COIN;
            w_coin = COIN_B_V;
        end else if (flag_key[KEY_COIN_A]) begin
            w_ev   = EV_COIN;
            w_coin = COIN_A_V;
        end
    end

    assign w_sum = {1'b0, r_credit} + {1'b0, w_coin};

    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_credit   <= '0;
            r_hold     <= '0;
            dispensing <= 1'b0;
            dispense_p <= 1'b0;
            change_vld <= 1'b0;
            change_amt <= '0;
            coin_rej   <= 1'b0;
            short_p    <= 1'b0;
        end else begin
            dispense_p <= 1'b0;
            change_vld <= 1'b0;
            coin_rej   <= 1'b0;
            short_p    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    change_amt <= '0;
                    if (w_ev == EV_COIN) begin
                        r_credit <= w_coin;
                        r_state  <= ST_ACCUM;
                    end else if (w_ev == EV_BUY) begin
                        short_p <= 1'b1;
                    end
                end
                ST_ACCUM: begin
                    case (w_ev)
                        EV_COIN: begin
                            if (w_sum <= MAX_V) r_credit <= w_sum[7:0];
                            else                coin_rej <= 1'b1;
                        end
                        EV_BUY: begin
                            if (r_credit >= PRICE_V) begin
                                r_credit   <= r_credit - PRICE_V;
                                r_hold     <= '0;
                                dispensing <= 1'b1;
                                dispense_p <= 1'b1;
                                r_state    <= ST_DISPENSE;
                            end else begin
                                short_p <= 1'b1;
                            end
                        end
                        EV_CANCEL: begin
                            change_amt <= r_credit;
                            change_vld <= 1'b1;
                            r_credit   <= '0;
                            r_state    <= ST_CHANGE;
                        end
                        default: ;
                    endcase
                end
                ST_DISPENSE: begin
                    if (w_ev == EV_COIN) coin_rej <= 1'b1;
                    if (r_hold == HOLD_LAST) begin
                        dispensing <= 1'b0;
                        if (r_credit != '0) begin
                            change_amt <= r_credit;
                            change_vld <= 1'b1;
                            r_credit   <= '0;
                            r_state    <= ST_CHANGE;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                ST_CHANGE: begin
                    // A coin landing in the single change cycle is not
                    // counted, so it is reported as refused.
                    if (w_ev == EV_COIN) coin_rej <= 1'b1;
                    change_amt <= '0;
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // During CHANGE the credit is already cleared; show the refund instead.
    assign w_src   = (r_state == ST_CHANGE) ? change_amt : r_credit;
    assign w_start = (w_src != r_last_src);

    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            r_last_src <= '0;
            r_bcd_low  <= '0;
        end else begin
            r_last_src <= w_src;
            if (w_done) r_bcd_low <= w_bcd;
        end
    end

    bin2bcd_seq u_bcd (
        .sclk    (sclk),
        .rst_n   (rst_n),
        .i_start (w_start),
        .i_bin   (w_src),
        .o_bcd   (w_bcd),
        .o_done  (w_done)
    );

    assign rNum = {PRICE_BCD, r_bcd_low};

endmodule

// File: tb/tb_vend_ctrl.sv
module tb_vend_ctrl;

    logic        sclk = 1'b0;
    logic        rst_n;
    logic [3:0]  flag_key, flag_key_l;
    logic [23:0] rNum, rNum_l;
    logic        dispensing, dispense_p, change_vld, coin_rej, short_p;
    logic        dispensing_l, dispense_p_l, change_vld_l, coin_rej_l, short_p_l;
    logic [7:0]  change_amt, change_amt_l;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 sclk = ~sclk;

    vend_ctrl #(.PRICE(25), .COIN_A(5), .COIN_B(10), .MAX_CREDIT(95), .HOLD_CYC(4)) dut (
        .sclk(sclk), .rst_n(rst_n), .flag_key(flag_key), .rNum(rNum),
        .dispensing(dispensing), .dispense_p(dispense_p), .change_vld(change_vld),
        .change_amt(change_amt), .coin_rej(coin_rej), .short_p(short_p)
    );

    // Long hold so the pending change is visible on the display during DISPENSE.
    vend_ctrl #(.PRICE(25), .COIN_A(5), .COIN_B(10), .MAX_CREDIT(95), .HOLD_CYC(16)) dut_long (
        .sclk(sclk), .rst_n(rst_n), .flag_key(flag_key_l), .rNum(rNum_l),
        .dispensing(dispensing_l), .dispense_p(dispense_p_l), .change_vld(change_vld_l),
        .change_amt(change_amt_l), .coin_rej(coin_rej_l), .short_p(short_p_l)
    );

    typedef struct {
        logic [3:0]  key;
        logic        rej;
        logic        shrt;
        logic        cv;
        logic [7:0]  amt;
        logic [11:0] low;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge sclk);
        flag_key = k;
        @(posedge sclk);
        #1;
        flag_key = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge sclk);
        #1;
    endtask

    // Press buy, then watch 20 sample points starting at the buy edge.
    task automatic run_buy(output int dp, output int ds, output int cv, output logic [7:0] amt);
        dp = 0; ds = 0; cv = 0; amt = '0;
        press(4'b0100);
        for (int i = 0; i < 20; i++) begin
            if (i > 0) idle(1);
            if (dispense_p) dp++;
            if (dispensing) ds++;
            if (change_vld) begin cv++; amt = change_amt; end
        end
    endtask

    initial begin
        int dp, ds, cv;
        logic [7:0] amt;
        logic seen;

        flag_key   = '0;
        flag_key_l = '0;
        rst_n      = 1'b0;

        vecs[0]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 8'd0,  12'h005};
        vecs[1]  = '{4'b0100, 1'b0, 1'b1, 1'b0, 8'd0,  12'h005};
        vecs[2]  = '{4'b1000, 1'b0, 1'b0, 1'b1, 8'd5,  12'h000};
        vecs[3]  = '{4'b0100, 1'b0, 1'b1, 1'b0, 8'd0,  12'h000};
        vecs[4]  = '{4'b1000, 1'b0, 1'b0, 1'b0, 8'd0,  12'h000};
        vecs[5]  = '{4'b0011, 1'b0, 1'b0, 1'b0, 8'd0,  12'h010};
        for (int i = 0; i < 8; i++)
            vecs[6+i] = '{4'b0010, 1'b0, 1'b0, 1'b0, 8'd0, {4'd0, 4'(i + 2), 4'd0}};
        vecs[14] = '{4'b0010, 1'b1, 1'b0, 1'b0, 8'd0,  12'h090};
        vecs[15] = '{4'b0001, 1'b0, 1'b0, 1'b0, 8'd0,  12'h095};
        vecs[16] = '{4'b0001, 1'b1, 1'b0, 1'b0, 8'd0,  12'h095};
        vecs[17] = '{4'b1111, 1'b0, 1'b0, 1'b1, 8'd95, 12'h000};

        // Reset and idle
        repeat (3) @(posedge sclk);
        @(negedge sclk);
        rst_n = 1'b1;
        idle(20);
        check("reset_rNum", 32'(rNum), 32'h025000);
        check("reset_pulses", 32'({dispensing, dispense_p, change_vld, coin_rej, short_p}), 32'd0);
        check("reset_change_amt", 32'(change_amt), 32'd0);

        // Table-driven single-key vectors
        for (int i = 0; i < 18; i++) begin
            press(vecs[i].key);
            check($sformatf("v%0d_coin_rej", i),   32'(coin_rej),   32'(vecs[i].rej));
            check($sformatf("v%0d_short_p", i),    32'(short_p),    32'(vecs[i].shrt));
            check($sformatf("v%0d_change_vld", i), 32'(change_vld), 32'(vecs[i].cv));
            check($sformatf("v%0d_change_amt", i), 32'(change_amt), 32'(vecs[i].amt));
            check($sformatf("v%0d_dispense", i),   32'({dispense_p, dispensing}), 32'd0);
            idle(12);
            check($sformatf("v%0d_rNum", i), 32'(rNum), {8'd0, 12'h025, vecs[i].low});
        end

        // Exact-price sale: B, B, A, buy
        press(4'b0010); idle(12); check("s1_rNum_10", 32'(rNum[11:0]), 32'h010);
        press(4'b0010); idle(12); check("s1_rNum_20", 32'(rNum[11:0]), 32'h020);
        press(4'b0001); idle(12); check("s1_rNum_25", 32'(rNum[11:0]), 32'h025);
        run_buy(dp, ds, cv, amt);
        check("s1_dispense_p_cnt", 32'(dp), 32'd1);
        check("s1_dispensing_cnt", 32'(ds), 32'd4);
        check("s1_change_vld_cnt", 32'(cv), 32'd0);
        check("s1_rNum_after", 32'(rNum[11:0]), 32'h000);

        // Sale with change: B x3, buy
        repeat (3) press(4'b0010);
        idle(12);
        check("s2_rNum_30", 32'(rNum[11:0]), 32'h030);
        run_buy(dp, ds, cv, amt);
        check("s2_dispense_p_cnt", 32'(dp), 32'd1);
        check("s2_dispensing_cnt", 32'(ds), 32'd4);
        check("s2_change_vld_cnt", 32'(cv), 32'd1);
        check("s2_change_amt", 32'(amt), 32'd5);
        check("s2_change_amt_idle", 32'(change_amt), 32'd0);

        // Coin during DISPENSE is refused and not counted (35 -> change 10)
        repeat (3) press(4'b0010);
        press(4'b0001);
        idle(12);
        press(4'b0100);
        check("s3_dispense_p", 32'(dispense_p), 32'd1);
        press(4'b0001);
        check("s3_coin_rej", 32'(coin_rej), 32'd1);
        check("s3_dispensing", 32'(dispensing), 32'd1);
        seen = 1'b0;
        amt  = '0;
        for (int i = 0; i < 15; i++) begin
            idle(1);
            if (change_vld && !seen) begin seen = 1'b1; amt = change_amt; end
        end
        check("s3_change_seen", 32'(seen), 32'd1);
        check("s3_change_amt", 32'(amt), 32'd10);

        // Reset in the middle of DISPENSE
        repeat (3) press(4'b0010);
        idle(12);
        press(4'b0100);
        idle(1);
        check("s4_in_dispense", 32'(dispensing), 32'd1);
        @(negedge sclk);
        rst_n = 1'b0;
        @(posedge sclk);
        #1;
        check("s4_rst_dispensing", 32'(dispensing), 32'd0);
        check("s4_rst_rNum", 32'(rNum), 32'h025000);
        rst_n = 1'b1;
        cv = 0; dp = 0;
        for (int i = 0; i < 15; i++) begin
            idle(1);
            if (change_vld) cv++;
            if (dispense_p) dp++;
        end
        check("s4_no_change_vld", 32'(cv), 32'd0);
        check("s4_no_dispense_p", 32'(dp), 32'd0);
        press(4'b0001);
        idle(12);
        check("s4_fresh_credit", 32'(rNum[11:0]), 32'h005);
        press(4'b1000);
        check("s4_cancel_amt", 32'(change_amt), 32'd5);

        // Pending change shown during DISPENSE (long-hold instance)
        for (int i = 0; i < 3; i++) begin
            @(negedge sclk); flag_key_l = 4'b0010;
            @(negedge sclk); flag_key_l = 4'b0000;
        end
        @(negedge sclk); flag_key_l = 4'b0100;
        @(posedge sclk); #1;
        flag_key_l = 4'b0000;
        check("s5_dispense_p", 32'(dispense_p_l), 32'd1);
        idle(11);
        check("s5_dispensing", 32'(dispensing_l), 32'd1);
        check("s5_rNum_change", 32'(rNum_l), 32'h025005);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vend_ctrl.md
Name: vend_ctrl

Overview:
Coin-accounting and sale controller for the coke vending machine. Consumes the one-cycle debounced key flags from the key stage, keeps the inserted credit, decides sale/refund and produces a 24-bit six-digit BCD display word for the seven-segment and LED stages. Also emits dispense and change strobes for the actuator side.

Parameters:
PRICE, 25, item price in jiao (0.1 yuan), 1..MAX_CREDIT
COIN_A, 5, value of key 0 (0.5 yuan) in jiao
COIN_B, 10, value of key 1 (1 yuan) in jiao
MAX_CREDIT, 95, credit ceiling in jiao (≤255)
HOLD_CYC, 50_000_000, cycles the dispense state is held (1 s at 50 MHz; bench uses 4)

Ports:
sclk  in  1  system clock
rst_n  in  1  synchronous reset, active low
flag_key  in  4  one-cycle key pulses: [0] coin A, [1] coin B, [2] buy, [3] cancel
rNum  out  24  BCD display: [23:12] price (3 digits), [11:0] credit or change (3 digits)
dispensing  out  1  high for whole DISPENSE state
dispense_p  out  1  one-cycle pulse on DISPENSE entry
change_vld  out  1  one-cycle change/refund strobe
change_amt  out  8  change in jiao, valid with change_vld, else 0
coin_rej  out  1  one-cycle pulse, coin refused (would exceed MAX_CREDIT)
short_p  out  1  one-cycle pulse, buy pressed with credit < PRICE

Behaviour:
- One clock sclk; reset synchronous active-low on rst_n, sampled on sclk rising edge.
- Reset values: state IDLE, credit 0, hold counter 0, all pulses/levels 0, change_amt 0, rNum = {PRICE BCD, 12'h000}.
- Key priority when several flag bits are set in one cycle: cancel > buy > coin B > coin A; only the winner is serviced, the rest are dropped.
- States: IDLE, ACCUM, DISPENSE, CHANGE.
- IDLE: coin accepted -> credit = coin value, go ACCUM. Buy -> short_p (credit 0 < PRICE). Cancel ignored.
- ACCUM: coin with credit+value ≤ MAX_CREDIT -> credit += value; otherwise coin_rej, credit unchanged. Buy with credit ≥ PRICE -> DISPENSE, credit -= PRICE in the same edge. Buy with credit < PRICE -> short_p, stay. Cancel -> CHANGE with change_amt = credit, credit 0.
- DISPENSE: dispense_p in first cycle, dispensing high; hold counter counts 0..HOLD_CYC-1, then -> CHANGE if credit > 0 (change_amt = credit, credit 0), else -> IDLE. All flag_key ignored (coins arriving here are not counted and raise coin_rej).
- CHANGE: one cycle; change_vld = 1 with change_amt; next cycle -> IDLE, change_amt back to 0.
- Credit arithmetic 8-bit unsigned, 9-bit intermediate for ceiling check; no wrap is ever possible.
- Display: credit field shows credit in IDLE/ACCUM, shows pending change in DISPENSE/CHANGE. Binary-to-BCD is done sequentially; rNum low field updates ≤ 10 cycles after the source value changes; a new value during conversion restarts it; rNum holds old value until conversion done (never shows partial BCD). Price field is constant.
- Reset mid-operation (any state): returns to reset values next edge; no change_vld or dispense_p is emitted for the aborted transaction.

Decomposition:
- Shared package: state encoding (IDLE, ACCUM, DISPENSE, CHANGE), key bit index constants (KEY_COIN_A=0, KEY_COIN_B=1, KEY_BUY=2, KEY_CANCEL=3), elaboration-time bin-to-BCD function for the constant price field.
- One sub-module: bin2bcd_seq — 8-bit binary in, 12-bit BCD out, start/done, shift-add-3 over 8 iterations, same sclk/rst_n.

Test Plan:
- Reset then idle 20 cycles -> rNum = 24'h025_000, all pulses 0.
- Coin B, coin B, coin A, buy (HOLD_CYC=4) -> credit 10,20,25 shown as 0x010,0x020,0x025; dispense_p once, dispensing 4 cycles, no change_vld, return IDLE, rNum low = 0x000.
- Coin B ×3, buy -> dispense, then change_vld with change_amt = 5, rNum low shows 0x005 during DISPENSE.
- Coin A, buy -> short_p, credit stays 5; cancel -> change_vld, change_amt = 5, IDLE.
- Coin B ×9 then coin B -> credit 90, tenth coin gives coin_rej, credit 90; coin A -> 95; flag_key = 4'b1111 -> cancel wins, change_amt = 95.
- In DISPENSE assert rst_n low one cycle -> next edge IDLE, no change_vld, rNum low 0x000; coin during DISPENSE -> coin_rej, credit unchanged.
